fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_redirect_mux.sv | 18 +
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [31:0] WORD_ZERO = '0;
    localparam logic [31:0] PC_INCR   = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_unit_redirect_mux.sv
// Redirect target selection: branch wins over jump, result is word-aligned.
module fetch_unit_redirect_mux
    import fetch_unit_pkg::*;
(
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        redirect,
    output logic [31:0] target
);

    always_comb begin
        redirect = br_taken | jmp;
        target   = align_word(br_taken ? br_target : jmp_target);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, a one-entry hold buffer
// for decode, and redirect handling that drops in-flight data.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target
);

    state_e      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        discard_q, discard_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    logic        redirect;
    logic [31:0] redir_target;

    fetch_unit_redirect_mux u_redirect_mux (
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .redirect   (redirect),
        .target     (redir_target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_addr_q <= WORD_ZERO;
            discard_q  <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= WORD_ZERO;
            if_pc_q    <= WORD_ZERO;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        case (state_q)
            S_IDLE: begin
                state_d    = S_REQ;
                req_addr_d = redirect ? redir_target : align_word(pc_in);
            end
            S_REQ: begin
                if (imem_ack) begin
                    discard_d = 1'b0;
                    // Stale or redirected responses re-issue; only a clean ack fills the buffer.
                    if (redirect) begin
                        req_addr_d = redir_target;
                    end else if (discard_q) begin
                        req_addr_d = align_word(pc_in);
                    end else begin
                        state_d    = S_HOLD;
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = req_addr_q;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || id_ready) begin
                    state_d    = S_REQ;
                    if_valid_d = 1'b0;
                    req_addr_d = redirect ? redir_target : align_word(pc_in);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == S_REQ);
        imem_addr = req_addr_q;
        if_valid  = if_valid_q;
        if_instr  = if_instr_q;
        if_pc     = if_pc_q;
        if (rst) begin
            pc_next = WORD_ZERO;
        end else if (redirect) begin
            pc_next = redir_target;
        end else if (state_q == S_REQ && imem_ack && !discard_q) begin
            pc_next = req_addr_q + PC_INCR;
        end else begin
            pc_next = pc_in;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, hand sequences, random run.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;

    int checks   = 0;
    int failures = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_next    (pc_next),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an outstanding request, a buffered instruction, a stale-data flag.
    logic        m_pending, m_have, m_discard;
    logic [31:0] m_req_addr, m_instr, m_ipc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] redir_tgt();
        logic [31:0] t;
        t = br_taken ? br_target : jmp_target;
        return {t[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] model_pc_next();
        if (rst) return 32'h0;
        if (br_taken || jmp) return redir_tgt();
        if (m_pending && imem_ack && !m_discard) return m_req_addr + 32'd4;
        return pc_in;
    endfunction

    task automatic model_step();
        logic        redir;
        logic [31:0] t;
        redir = br_taken || jmp;
        t     = redir_tgt();
        if (rst) begin
            m_pending = 0; m_have = 0; m_discard = 0;
            m_req_addr = 0; m_instr = 0; m_ipc = 0;
        end else if (!m_pending && !m_have) begin
            m_pending  = 1;
            m_req_addr = redir ? t : {pc_in[31:2], 2'b00};
        end else if (m_pending) begin
            if (imem_ack) begin
                if (redir) begin
                    m_req_addr = t; m_discard = 0;
                end else if (m_discard) begin
                    m_req_addr = {pc_in[31:2], 2'b00}; m_discard = 0;
                end else begin
                    m_pending = 0; m_have = 1;
                    m_instr = imem_rdata; m_ipc = m_req_addr;
                end
            end else if (redir) begin
                m_discard = 1;
            end
        end else if (redir || id_ready) begin
            m_have     = 0;
            m_pending  = 1;
            m_req_addr = redir ? t : {pc_in[31:2], 2'b00};
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at negedge: apply inputs, memory answers at the registered address.
    task automatic drive(input logic r, input logic a, input logic idr, input logic b,
                         input logic [31:0] bt, input logic j, input logic [31:0] jt);
        rst = r; imem_ack = a; id_ready = idr;
        br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
        #1;
        imem_rdata = a ? mem_word(imem_addr) : $urandom;
        #1;
    endtask

    task automatic check_model();
        chk("m_imem_req",  32'(imem_req),  32'(m_pending));
        chk("m_imem_addr", imem_addr,      m_req_addr);
        chk("m_if_valid",  32'(if_valid),  32'(m_have));
        chk("m_if_pc",     if_pc,          m_ipc);
        chk("m_if_instr",  if_instr,       m_instr);
        chk("m_pc_next",   pc_next,        model_pc_next());
    endtask

    // The PC register of the surrounding pipeline loads pc_next every edge.
    task automatic advance();
        logic [31:0] pn;
        pn = pc_next;
        @(posedge clk);
        model_step();
        #1;
        pc_in = pn;
        @(negedge clk);
    endtask

    typedef struct {
        logic        r, a, idr, b;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pcn;
        logic [31:0] e_ifpc;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic r, input logic a, input logic idr, input logic b,
                                input logic [31:0] bt, input logic j, input logic [31:0] jt,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] epn, input logic [31:0] eip);
        vec_t v;
        v.r = r; v.a = a; v.idr = idr; v.b = b; v.bt = bt; v.j = j; v.jt = jt;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pcn = epn; v.e_ifpc = eip;
        return v;
    endfunction

    initial begin
        rst = 1; pc_in = 0; imem_ack = 0; imem_rdata = 0; id_ready = 0;
        br_taken = 0; br_target = 0; jmp = 0; jmp_target = 0;
        m_pending = 0; m_have = 0; m_discard = 0; m_req_addr = 0; m_instr = 0; m_ipc = 0;

        //            r a i b bt        j jt       req addr       v pc_next    if_pc
        tbl[0]  = mk(1,0,0,0,32'h0,    0,32'h0,   0, 32'h0,      0,32'h0,     32'h0);
        tbl[1]  = mk(0,0,0,0,32'h0,    0,32'h0,   0, 32'h0,      0,32'h0,     32'h0);
        tbl[2]  = mk(0,0,0,0,32'h0,    0,32'h0,   1, 32'h0,      0,32'h0,     32'h0);
        tbl[3]  = mk(0,1,0,0,32'h0,    0,32'h0,   1, 32'h0,      0,32'h4,     32'h0);
        tbl[4]  = mk(0,0,1,0,32'h0,    0,32'h0,   0, 32'h0,      1,32'h4,     32'h0);
        tbl[5]  = mk(0,0,0,0,32'h0,    0,32'h0,   1, 32'h4,      0,32'h4,     32'h0);
        tbl[6]  = mk(0,1,0,0,32'h0,    0,32'h0,   1, 32'h4,      0,32'h8,     32'h0);
        tbl[7]  = mk(0,0,1,0,32'h0,    0,32'h0,   0, 32'h4,      1,32'h8,     32'h4);
        tbl[8]  = mk(0,0,0,0,32'h0,    0,32'h0,   1, 32'h8,      0,32'h8,     32'h4);
        tbl[9]  = mk(0,1,0,0,32'h0,    0,32'h0,   1, 32'h8,      0,32'hC,     32'h4);
        tbl[10] = mk(0,0,0,0,32'h0,    0,32'h0,   0, 32'h8,      1,32'hC,     32'h8);
        tbl[11] = mk(0,0,0,0,32'h0,    0,32'h0,   0, 32'h8,      1,32'hC,     32'h8);
        tbl[12] = mk(0,0,0,0,32'h0,    0,32'h0,   0, 32'h8,      1,32'hC,     32'h8);
        tbl[13] = mk(0,0,0,1,32'h103,  0,32'h0,   0, 32'h8,      1,32'h100,   32'h8);
        tbl[14] = mk(0,0,0,0,32'h0,    0,32'h0,   1, 32'h100,    0,32'h100,   32'h8);
        tbl[15] = mk(0,1,0,0,32'h0,    0,32'h0,   1, 32'h100,    0,32'h104,   32'h8);
        tbl[16] = mk(0,0,1,0,32'h0,    0,32'h0,   0, 32'h100,    1,32'h104,   32'h100);
        tbl[17] = mk(0,0,0,0,32'h0,    1,32'h40,  1, 32'h104,    0,32'h40,    32'h100);
        tbl[18] = mk(0,0,0,0,32'h0,    0,32'h0,   1, 32'h104,    0,32'h40,    32'h100);
        tbl[19] = mk(0,1,0,0,32'h0,    0,32'h0,   1, 32'h104,    0,32'h40,    32'h100);
        tbl[20] = mk(0,0,0,0,32'h0,    0,32'h0,   1, 32'h40,     0,32'h40,    32'h100);
        tbl[21] = mk(0,1,0,0,32'h0,    0,32'h0,   1, 32'h40,     0,32'h44,    32'h100);
        tbl[22] = mk(0,0,0,1,32'h20,   1,32'h80,  0, 32'h40,     1,32'h20,    32'h40);
        tbl[23] = mk(0,1,0,1,32'h200,  0,32'h0,   1, 32'h20,     0,32'h200,   32'h40);
        tbl[24] = mk(0,1,0,0,32'h0,    0,32'h0,   1, 32'h200,    0,32'h204,   32'h40);
        tbl[25] = mk(0,0,0,0,32'h0,    0,32'h0,   0, 32'h200,    1,32'h204,   32'h200);

        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0); advance();
        drive(1, 0, 0, 0, 0, 0, 0); advance();

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].r, tbl[i].a, tbl[i].idr, tbl[i].b, tbl[i].bt, tbl[i].j, tbl[i].jt);
            chk($sformatf("tbl%0d_req", i),   32'(imem_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i),  imem_addr,     tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_pcn", i),   pc_next,       tbl[i].e_pcn);
            chk($sformatf("tbl%0d_ifpc", i),  if_pc,         tbl[i].e_ifpc);
            if (tbl[i].e_valid)
                chk($sformatf("tbl%0d_instr", i), if_instr, mem_word(tbl[i].e_ifpc));
            check_model();
            advance();
        end

        // Wrap-around fetch at the top of the address space, then reset mid-request.
        drive(1, 0, 0, 0, 0, 0, 0); advance();
        pc_in = 32'hFFFF_FFFC;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_idle_pcn", pc_next, 32'hFFFF_FFFC);
        check_model(); advance();
        drive(0, 0, 0, 0, 0, 0, 0); check_model(); advance();
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pcn", pc_next, 32'h0000_0000);
        check_model(); advance();
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("wrap_instr", if_instr, mem_word(32'hFFFF_FFFC));
        check_model(); advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_next_req", imem_addr, 32'h0);
        check_model(); advance();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rst_pcn", pc_next, 32'h0);
        advance();
        drive(0, 1, 1, 0, 0, 0, 0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ifpc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("late_ack_pcn", pc_next, 32'h0);
        check_model(); advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("late_ack_valid", 32'(if_valid), 32'h0);
        chk("late_ack_req", 32'(imem_req), 32'h1);
        check_model(); advance();

        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 64) == 0, $urandom % 2, $urandom % 2,
                  ($urandom % 8) == 0, $urandom, ($urandom % 8) == 0, $urandom);
            check_model();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
